// File: rtl/seq_pkg.sv
// seq_pkg -- definitions shared by the serial-sequence blocks.
//
// Contents:
//   state_t         FSM state encoding of seq_gen (IDLE, SHIFT, PARITY)
//   SEQ_SIZE        default word length (also used by seq_detect benches)
//   SEQ_BIT_CYCLES  default clocks per serial bit
//   cnt_width()     counter width for a modulus, never less than 1 bit
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int SEQ_SIZE       = 32;
  localparam int SEQ_BIT_CYCLES = 2;

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_gen_tick.sv
// seq_gen_tick -- bit-period counter for seq_gen.
//
// Counts 0..BIT_CYCLES-1 while enabled and raises tick during the last count,
// so the owner acts on the edge where the counter wraps back to 0.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   clear   in   synchronous clear to 0 (has priority over enable)
//   enable  in   advance the counter this cycle
//   tick    out  high in the cycle whose closing edge wraps the counter
module seq_gen_tick
  import seq_pkg::*;
#(
  parameter int BIT_CYCLES = SEQ_BIT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the reset branch is in the sensitivity list because the
  // reset must act without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seq_gen.sv
// seq_gen -- bit-serial sequence generator.
//
// Accepts a SIZE-bit word via a ready/load handshake and shifts it out
// MSB-first on seq, holding each bit for BIT_CYCLES clocks. seq, busy and
// done are registered; ready is decoded directly from the state register.
//
// Build option: define SEQ_GEN_PARITY_EN to append one even-parity bit
// (XOR of the captured word) after the data bits.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   data   in   word to transmit, sampled only on an accepted load
//   load   in   request to start transmission of data
//   ready  out  load will be accepted (state IDLE)
//   seq    out  serial output, MSB first, idle level 0
//   busy   out  high while a frame is being shifted out
//   done   out  one-cycle pulse in the first IDLE cycle after a frame
module seq_gen
  import seq_pkg::*;
#(
  parameter int SIZE       = SEQ_SIZE,
  parameter int BIT_CYCLES = SEQ_BIT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] data,
  input  logic            load,
  output logic            ready,
  output logic            seq,
  output logic            busy,
  output logic            done
);

  localparam int            BW       = cnt_width(SIZE);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);

  state_t          state, state_d;
  logic [SIZE-1:0] shreg, shreg_d;
  logic [BW-1:0]   bit_cnt, bit_cnt_d;
  logic            tick;
  logic            accept;
  logic            seq_d, busy_d, done_d;
`ifdef SEQ_GEN_PARITY_EN
  logic            par_q, par_d;
`endif

  assign ready  = (state == IDLE);
  assign accept = load && ready;

  // The period counter sits at 0 throughout IDLE, so the first bit of a
  // frame always gets a full BIT_CYCLES period.
  seq_gen_tick #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .enable(state != IDLE),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and datapath-next logic.
  always_comb begin
    // NOTE: every signal gets its hold value first so that no path through
    // the case leaves one unassigned, which would infer a latch.
    state_d   = state;
    shreg_d   = shreg;
    bit_cnt_d = bit_cnt;
`ifdef SEQ_GEN_PARITY_EN
    par_d     = par_q;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_d   = SHIFT;
          shreg_d   = data;
          bit_cnt_d = BIT_LAST;
`ifdef SEQ_GEN_PARITY_EN
          par_d     = ^data;
`endif
        end
      end
      SHIFT: begin
        if (tick) begin
          shreg_d = shreg << 1;
          if (bit_cnt == '0) begin
`ifdef SEQ_GEN_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end else begin
            // Stops at 0: the last wrap leaves SHIFT instead of underflowing.
            bit_cnt_d = bit_cnt - BW'(1);
          end
        end
      end
      PARITY: begin
`ifdef SEQ_GEN_PARITY_EN
        if (tick) begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: decoded from the next state so the registered outputs line
  // up with the state they describe, with no extra cycle of latency.
  always_comb begin
    seq_d  = 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == IDLE) && (state != IDLE);
    case (state_d)
      SHIFT:   seq_d = shreg_d[SIZE-1];
`ifdef SEQ_GEN_PARITY_EN
      PARITY:  seq_d = par_d;
`endif
      default: seq_d = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
      seq     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      seq     <= seq_d;
      busy    <= busy_d;
      done    <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule
